mastermind_scorer: RTL and testbench

MASTERMIND_SCORER -- requirements
Module: mastermind_scorer

---
 rtl/mastermind_scorer_pkg.sv | 26 ++
 rtl/mastermind_color_hist.sv | 38 +++
 rtl/mastermind_scorer.sv | 129 ++++++++++++
 tb/tb_mastermind_scorer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mastermind_scorer_pkg.sv
// Shared types and constants for the Mastermind row scorer.
// Holds the FSM encoding, peg/color geometry and the feedback field widths.
package mastermind_scorer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXACT,
        ST_COUNT,
        ST_WRITE
    } state_t;

    localparam int COLOR_GRAY = 0;
    localparam int NUM_COLORS = 6;
    localparam int PEG_W      = 3;
    localparam int N_PEGS     = 4;
    localparam int N_ROWS     = 6;
    localparam int CNT_W      = 3;
    localparam int FB_W       = 2 * CNT_W;

    function automatic logic [CNT_W-1:0] cnt_min(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/mastermind_color_hist.sv
// Paired per-color histograms (guess side and answer side) for unmatched pegs.
// Both sides bump together on each non-exact peg and are read by one shared color index.
module mastermind_color_hist
    import mastermind_scorer_pkg::*;
(
    input  logic             sys_clk,
    input  logic             reset_db,
    input  logic             clear,
    input  logic             inc_en,
    input  logic [PEG_W-1:0] guess_color,
    input  logic [PEG_W-1:0] answer_color,
    input  logic [PEG_W-1:0] rd_color,
    output logic [CNT_W-1:0] guess_cnt,
    output logic [CNT_W-1:0] answer_cnt
);

    localparam int N_BINS = 1 << PEG_W;

    logic [N_BINS-1:0][CNT_W-1:0] g_hist;
    logic [N_BINS-1:0][CNT_W-1:0] a_hist;

    always_ff @(posedge sys_clk or posedge reset_db) begin
        if (reset_db) begin
            g_hist <= '0;
            a_hist <= '0;
        end else if (clear) begin
            g_hist <= '0;
            a_hist <= '0;
        end else if (inc_en) begin
            g_hist[guess_color]  <= g_hist[guess_color] + CNT_W'(1);
            a_hist[answer_color] <= a_hist[answer_color] + CNT_W'(1);
        end
    end

    assign guess_cnt  = g_hist[rd_color];
    assign answer_cnt = a_hist[rd_color];

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: one peg per cycle for exact hits, then one color
// per cycle for color-only hits; results land in a per-row feedback table.
module mastermind_scorer
    import mastermind_scorer_pkg::*;
#(
    parameter int N_ROWS = 6,
    parameter int N_PEGS = 4
) (
    input  logic                      sys_clk,
    input  logic                      reset_db,
    input  logic                      start,
    input  logic [2:0]                guess_row,
    input  logic [PEG_W*N_PEGS-1:0]   guess_word,
    input  logic [PEG_W*N_PEGS-1:0]   answer,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          exact_cnt,
    output logic [CNT_W-1:0]          partial_cnt,
    output logic                      win,
    output logic [FB_W*N_ROWS-1:0]    feedback_flat,
    output logic [N_ROWS-1:0]         row_valid
);

    localparam int PI_W = $clog2(N_PEGS);

    state_t                    state, state_nx;
    logic [2:0]                step;
    logic                      last_step;
    logic [PEG_W*N_PEGS-1:0]   g_lat, a_lat;
    logic [2:0]                row_lat;
    logic [N_PEGS-1:0]         match_mask;
    logic [CNT_W-1:0]          partial_acc, partial_sum, exact_cur;
    logic [CNT_W-1:0]          g_cnt, a_cnt;
    logic [PEG_W-1:0]          g_peg, a_peg, rd_color;
    logic                      start_ok, is_exact, hist_inc;

    assign start_ok = start && (int'(guess_row) < N_ROWS);
    assign g_peg    = g_lat[PEG_W*int'(step) +: PEG_W];
    assign a_peg    = a_lat[PEG_W*int'(step) +: PEG_W];
    assign is_exact = (state == ST_EXACT) && (g_peg == a_peg) && (g_peg != PEG_W'(COLOR_GRAY));
    assign hist_inc = (state == ST_EXACT) && !is_exact;
    // COUNT walks colors 1..NUM_COLORS, so gray (bin 0) is never read back
    assign rd_color    = PEG_W'(step) + PEG_W'(1);
    assign partial_sum = partial_acc + cnt_min(g_cnt, a_cnt);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_WRITE);

    always_comb begin
        exact_cur = '0;
        for (int i = 0; i < N_PEGS; i++)
            exact_cur = exact_cur + CNT_W'(match_mask[i]);
    end

    always_ff @(posedge sys_clk or posedge reset_db) begin
        if (reset_db) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        last_step = 1'b0;
        case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = ST_EXACT;
            ST_EXACT: begin
                last_step = (step == 3'(N_PEGS - 1));
                if (last_step) state_nx = ST_COUNT;
            end
            ST_COUNT: begin
                last_step = (step == 3'(NUM_COLORS - 1));
                if (last_step) state_nx = ST_WRITE;
            end
            ST_WRITE: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    mastermind_color_hist u_hist (
        .sys_clk      (sys_clk),
        .reset_db     (reset_db),
        .clear        (state == ST_LOAD),
        .inc_en       (hist_inc),
        .guess_color  (g_peg),
        .answer_color (a_peg),
        .rd_color     (rd_color),
        .guess_cnt    (g_cnt),
        .answer_cnt   (a_cnt)
    );

    // Results are registered on the edge into WRITE so they are valid alongside done
    always_ff @(posedge sys_clk or posedge reset_db) begin
        if (reset_db) begin
            step          <= '0;
            g_lat         <= '0;
            a_lat         <= '0;
            row_lat       <= '0;
            match_mask    <= '0;
            partial_acc   <= '0;
            exact_cnt     <= '0;
            partial_cnt   <= '0;
            win           <= 1'b0;
            feedback_flat <= '0;
            row_valid     <= '0;
        end else begin
            step <= (state_nx != state) ? 3'd0 : step + 3'd1;
            if (state == ST_IDLE && start_ok) begin
                g_lat       <= guess_word;
                a_lat       <= answer;
                row_lat     <= guess_row;
                match_mask  <= '0;
                partial_acc <= '0;
            end
            if (is_exact) match_mask[step[PI_W-1:0]] <= 1'b1;
            if (state == ST_COUNT) partial_acc <= partial_sum;
            if (state == ST_COUNT && last_step) begin
                exact_cnt   <= exact_cur;
                partial_cnt <= partial_sum;
                win         <= (exact_cur == CNT_W'(N_PEGS));
                for (int r = 0; r < N_ROWS; r++) begin
                    if (row_lat == 3'(r)) begin
                        feedback_flat[FB_W*r +: FB_W] <= {partial_sum, exact_cur};
                        row_valid[r]                  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed bench for mastermind_scorer: latency, scoring cases, ignored starts,
// overwrite of a scored row, and an abort by reset in the middle of COUNT.
module tb_mastermind_scorer;

    logic        sys_clk = 1'b0;
    logic        reset_db = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  guess_row = '0;
    logic [11:0] guess_word = '0;
    logic [11:0] answer = '0;
    logic        busy, done, win;
    logic [2:0]  exact_cnt, partial_cnt;
    logic [35:0] feedback_flat;
    logic [5:0]  row_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    int busy_bad;
    int extra_done;

    mastermind_scorer #(.N_ROWS(6), .N_PEGS(4)) dut (
        .sys_clk       (sys_clk),
        .reset_db      (reset_db),
        .start         (start),
        .guess_row     (guess_row),
        .guess_word    (guess_word),
        .answer        (answer),
        .busy          (busy),
        .done          (done),
        .exact_cnt     (exact_cnt),
        .partial_cnt   (partial_cnt),
        .win           (win),
        .feedback_flat (feedback_flat),
        .row_valid     (row_valid)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start and wait (bounded) for done; cycle k = k-th negedge after the sampling edge.
    // With disturb set, inputs are scrambled after launch and a second start arrives at cycle 5.
    task automatic run_op(input logic [2:0] row, input logic [11:0] g, input logic [11:0] a,
                          input bit disturb, output int latency, output int bbad);
        @(negedge sys_clk);
        start = 1'b1; guess_row = row; guess_word = g; answer = a;
        latency = -1;
        bbad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge sys_clk);
            if (k == 1) start = 1'b0;
            if (disturb && k == 2) begin
                guess_word = ~g; answer = 12'o0000; guess_row = 3'd4;
            end
            if (disturb && k == 5) start = 1'b1;
            if (disturb && k == 6) start = 1'b0;
            if (!busy) bbad++;
            if (done) begin
                latency = k;
                break;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int n_done, output int n_busy);
        n_done = 0;
        n_busy = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge sys_clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
    endtask

    initial begin
        int nd, nb;

        // reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fb", 64'(feedback_flat), 64'd0);
        chk("rst_rv", 64'(row_valid), 64'd0);
        reset_db = 1'b0;
        repeat (2) @(negedge sys_clk);

        // all-same code, full win on row 0
        run_op(3'd0, 12'o1111, 12'o1111, 1'b0, lat, busy_bad);
        chk("win_lat", 64'(lat), 64'd12);
        chk("win_busy", 64'(busy_bad), 64'd0);
        chk("win_exact", 64'(exact_cnt), 64'd4);
        chk("win_partial", 64'(partial_cnt), 64'd0);
        chk("win_flag", 64'(win), 64'd1);
        chk("win_fb0", 64'(feedback_flat[5:0]), 64'b000_100);
        chk("win_rv", 64'(row_valid), 64'b000001);
        @(negedge sys_clk);
        chk("win_done_drop", 64'(done), 64'd0);
        chk("win_busy_drop", 64'(busy), 64'd0);
        chk("win_hold", 64'({win, exact_cnt}), 64'b1_100);

        // all colors misplaced on row 2, inputs scrambled and a second start mid-op
        run_op(3'd2, 12'o4321, 12'o1234, 1'b1, lat, busy_bad);
        chk("perm_lat", 64'(lat), 64'd12);
        chk("perm_busy", 64'(busy_bad), 64'd0);
        chk("perm_ep", 64'({win, partial_cnt, exact_cnt}), 64'b0_100_000);
        chk("perm_fb2", 64'(feedback_flat[17:12]), 64'b100_000);
        chk("perm_fb0_kept", 64'(feedback_flat[5:0]), 64'b000_100);
        count_done(16, nd, nb);
        chk("perm_single_done", 64'(nd), 64'd0);
        chk("perm_no_rebusy", 64'(nb), 64'd0);
        chk("perm_rv", 64'(row_valid), 64'b000101);

        // duplicates and gray on row 1
        run_op(3'd1, 12'o0111, 12'o1122, 1'b0, lat, busy_bad);
        chk("dup_ep", 64'({partial_cnt, exact_cnt}), 64'b001_001);
        chk("dup_fb1", 64'(feedback_flat[11:6]), 64'b001_001);

        // all-gray guess on row 5
        run_op(3'd5, 12'o0000, 12'o1234, 1'b0, lat, busy_bad);
        chk("gray_ep", 64'({win, partial_cnt, exact_cnt}), 64'd0);
        chk("gray_rv", 64'(row_valid), 64'b100111);

        // out-of-range row is ignored
        @(negedge sys_clk);
        start = 1'b1; guess_row = 3'd6; guess_word = 12'o1111; answer = 12'o1111;
        @(negedge sys_clk);
        start = 1'b0;
        count_done(15, nd, nb);
        chk("row6_done", 64'(nd), 64'd0);
        chk("row6_busy", 64'(nb), 64'd0);
        chk("row6_hold", 64'({row_valid, exact_cnt}), {55'd0, 6'b100111, 3'd0});

        // rescoring row 0 overwrites its feedback
        run_op(3'd0, 12'o1243, 12'o1234, 1'b0, lat, busy_bad);
        chk("over_fb0", 64'(feedback_flat[5:0]), 64'b010_010);
        chk("over_win", 64'(win), 64'd0);

        // reset in the middle of COUNT aborts
        @(negedge sys_clk);
        start = 1'b1; guess_row = 3'd3; guess_word = 12'o1111; answer = 12'o1111;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (7) @(negedge sys_clk);
        reset_db = 1'b1;
        #1;
        chk("abort_busy", 64'({busy, done}), 64'd0);
        chk("abort_res", 64'({win, partial_cnt, exact_cnt}), 64'd0);
        chk("abort_fb", 64'(feedback_flat), 64'd0);
        chk("abort_rv", 64'(row_valid), 64'd0);
        @(negedge sys_clk);
        reset_db = 1'b0;
        count_done(12, nd, nb);
        chk("abort_no_done", 64'(nd), 64'd0);

        run_op(3'd3, 12'o5566, 12'o6655, 1'b0, lat, busy_bad);
        chk("post_lat", 64'(lat), 64'd12);
        chk("post_ep", 64'({partial_cnt, exact_cnt}), 64'b100_000);
        chk("post_fb3", 64'(feedback_flat), {28'd0, 6'b100_000, 18'd0});
        chk("post_rv", 64'(row_valid), 64'b001000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
